// File: rtl/mult_hilo_seq_if.sv
// EX-side request/stall, multiplier handshake and HI/LO access for mult_hilo_seq.
// The slave modport is the sequencer; the master is whoever drives EX and the multiplier.
interface mult_hilo_if #(
    parameter int W = 16
);
    logic             op_valid;
    logic             op_signed;
    logic [W-1:0]     op_a;
    logic [W-1:0]     op_b;
    logic             busy;
    logic             mul_start;
    logic [W-1:0]     mul_mult1;
    logic [W-1:0]     mul_mult2;
    logic             mul_done;
    logic [2*W-1:0]   mul_produto;
    logic             wr_hi;
    logic             wr_lo;
    logic [W-1:0]     wr_data;
    logic [W-1:0]     hi;
    logic [W-1:0]     lo;
    logic             err;

    modport master (
        output op_valid, op_signed, op_a, op_b, mul_done, mul_produto,
               wr_hi, wr_lo, wr_data,
        input  busy, mul_start, mul_mult1, mul_mult2, hi, lo, err
    );

    modport slave (
        input  op_valid, op_signed, op_a, op_b, mul_done, mul_produto,
               wr_hi, wr_lo, wr_data,
        output busy, mul_start, mul_mult1, mul_mult2, hi, lo, err
    );
endinterface

// File: rtl/mult_hilo_seq.sv
// MULT/MULTU sequencer: feeds magnitudes to an unsigned shift-add multiplier,
// sign-corrects the product and owns the HI/LO pair (including MTHI/MTLO writes).
module mult_hilo_seq #(
    parameter int W       = 16,
    parameter int GUARD   = 2,
    parameter int TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        rst,
    mult_hilo_if.slave  bus
);
    localparam int GW = (GUARD   < 1) ? 1 : $clog2(GUARD + 1);
    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [GW-1:0] GUARD_L   = GW'(GUARD);
    localparam logic [TW-1:0] TIMEOUT_L = TW'(TIMEOUT);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_FIX   = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;

    // -2^(W-1) negates to itself, which read back unsigned is the correct magnitude.
    function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic sgn);
        logic signed [W-1:0] xs;
        xs = x;
        if (sgn && xs < 0) return W'(-xs);
        return x;
    endfunction

    function automatic logic [2*W-1:0] sign_fix(input logic [2*W-1:0] p, input logic neg);
        return neg ? (~p + 1'b1) : p;
    endfunction

    logic [2:0]     state_q, state_d;
    logic [GW-1:0]  guard_q, guard_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           err_q, err_d;
    logic [W-1:0]   m1_q, m1_d;
    logic [W-1:0]   m2_q, m2_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;
    logic           neg_q, neg_d;
    logic [2*W-1:0] p_q, p_d;

    always_comb begin
        state_d = state_q;
        guard_d = guard_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        m1_d    = m1_q;
        m2_d    = m2_q;
        neg_d   = neg_q;
        p_d     = p_q;
        hi_d    = bus.wr_hi ? bus.wr_data : hi_q;
        lo_d    = bus.wr_lo ? bus.wr_data : lo_q;

        case (state_q)
            S_IDLE: begin
                if (bus.op_valid) begin
                    m1_d    = mag(bus.op_a, bus.op_signed);
                    m2_d    = mag(bus.op_b, bus.op_signed);
                    neg_d   = bus.op_signed & (bus.op_a[W-1] ^ bus.op_b[W-1]);
                    err_d   = 1'b0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                guard_d = GUARD_L;
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // done may still be high from the previous op until the guard drains
                if (guard_q != '0) guard_d = guard_q - 1'b1;
                tmo_d = tmo_q + 1'b1;
                if (bus.mul_done && guard_q == '0) begin
                    p_d     = bus.mul_produto;
                    state_d = S_FIX;
                end else if (tmo_q == TIMEOUT_L) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_FIX: begin
                p_d     = sign_fix(p_q, neg_q);
                state_d = S_WRITE;
            end
            S_WRITE: begin
                hi_d    = p_q[2*W-1:W];
                lo_d    = p_q[W-1:0];
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            guard_q <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            m1_q    <= '0;
            m2_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            guard_q <= guard_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            m1_q    <= m1_d;
            m2_q    <= m2_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Product and sign are only consumed after being loaded within the same op.
    always_ff @(posedge clk) begin
        neg_q <= neg_d;
        p_q   <= p_d;
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.mul_start = (state_q == S_ISSUE);
    assign bus.mul_mult1 = m1_q;
    assign bus.mul_mult2 = m2_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_mult_hilo_seq.sv
// Bench for mult_hilo_seq: behavioural multiplier with configurable latency and stale done,
// reference results from plain signed/unsigned arithmetic.
module tb_mult_hilo_seq;
    localparam int W       = 16;
    localparam int GUARD   = 2;
    localparam int TIMEOUT = 63;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_hilo_if #(.W(W)) bus ();

    mult_hilo_seq #(.W(W), .GUARD(GUARD), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Multiplier model: after a start it may keep the old done/product for stale_hold
    // cycles, then drops done, waits lat cycles and presents the new product.
    int             lat        = 2;
    int             stale_hold = 0;
    bit             mul_en     = 1'b1;
    int             age        = 0;
    int             cnt        = 0;
    bit             pend       = 1'b0;
    logic           mdone      = 1'b0;
    logic [2*W-1:0] mprod      = '0;

    assign bus.mul_done    = mdone;
    assign bus.mul_produto = mprod;

    always @(posedge clk) begin
        if (bus.mul_start) begin
            age  <= 0;
            cnt  <= lat;
            pend <= 1'b1;
            if (stale_hold == 0) mdone <= 1'b0;
        end else if (pend) begin
            age <= age + 1;
            if (age + 1 >= stale_hold) begin
                if (cnt == 0) begin
                    if (mul_en) begin
                        mdone <= 1'b1;
                        mprod <= (2*W)'(bus.mul_mult1) * (2*W)'(bus.mul_mult2);
                        pend  <= 1'b0;
                    end else begin
                        mdone <= 1'b0;
                    end
                end else begin
                    mdone <= 1'b0;
                    cnt   <= cnt - 1;
                end
            end
        end
    end

    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input bit sgn);
        longint va, vb;
        va = sgn ? longint'($signed(a)) : longint'(a);
        vb = sgn ? longint'($signed(b)) : longint'(b);
        return (2*W)'(va * vb);
    endfunction

    function automatic logic [W-1:0] ref_mag(input logic [W-1:0] x, input bit sgn);
        longint v;
        v = sgn ? longint'($signed(x)) : longint'(x);
        if (v < 0) v = -v;
        return W'(v);
    endfunction

    // Issue one op from IDLE and follow it until busy drops (bounded).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn,
                          output int starts, output logic [W-1:0] m1, output logic [W-1:0] m2,
                          output logic err_issue, output int cycles, output bit finished);
        @(negedge clk);
        bus.op_a      = a;
        bus.op_b      = b;
        bus.op_signed = sgn;
        bus.op_valid  = 1'b1;
        @(negedge clk);
        bus.op_valid = 1'b0;
        m1        = bus.mul_mult1;
        m2        = bus.mul_mult2;
        err_issue = bus.err;
        starts    = 0;
        cycles    = 0;
        finished  = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (bus.mul_start) starts++;
            if (!bus.busy) begin
                finished = 1'b1;
                break;
            end
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.op_valid  = 1'b0;
        bus.op_signed = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.wr_hi     = 1'b0;
        bus.wr_lo     = 1'b0;
        bus.wr_data   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
        n_checks++; if (bus.mul_start !== 1'b0) begin n_fail++; $display("FAIL reset_start got %0b want 0", bus.mul_start); end
        n_checks++; if (bus.err !== 1'b0)       begin n_fail++; $display("FAIL reset_err got %0b want 0", bus.err); end
        n_checks++; if (bus.hi !== '0)          begin n_fail++; $display("FAIL reset_hi got %h want 0", bus.hi); end
        n_checks++; if (bus.lo !== '0)          begin n_fail++; $display("FAIL reset_lo got %h want 0", bus.lo); end
        n_checks++; if (bus.mul_mult1 !== '0)   begin n_fail++; $display("FAIL reset_mult1 got %h want 0", bus.mul_mult1); end
        n_checks++; if (bus.mul_mult2 !== '0)   begin n_fail++; $display("FAIL reset_mult2 got %h want 0", bus.mul_mult2); end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [5] = '{16'h0003, 16'hFFFD, 16'hFFFD, 16'h8000, 16'h0000};
        logic [W-1:0] tb [5] = '{16'h0005, 16'h0005, 16'hFFFB, 16'h8000, 16'hFFF9};
        bit           ts [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        int starts, cyc; logic [W-1:0] m1, m2; logic e; bit fin;
        logic [2*W-1:0] exp;
        lat = 3;
        for (int k = 0; k < 5; k++) begin
            run_op(ta[k], tb[k], ts[k], starts, m1, m2, e, cyc, fin);
            exp = ref_prod(ta[k], tb[k], ts[k]);
            n_checks++; if (!fin)        begin n_fail++; $display("FAIL dir%0d_done busy never fell", k); end
            n_checks++; if (starts !== 1) begin n_fail++; $display("FAIL dir%0d_start got %0d pulses want 1", k, starts); end
            n_checks++; if (m1 !== ref_mag(ta[k], ts[k])) begin n_fail++; $display("FAIL dir%0d_mult1 got %h want %h", k, m1, ref_mag(ta[k], ts[k])); end
            n_checks++; if (m2 !== ref_mag(tb[k], ts[k])) begin n_fail++; $display("FAIL dir%0d_mult2 got %h want %h", k, m2, ref_mag(tb[k], ts[k])); end
            n_checks++; if ({bus.hi, bus.lo} !== exp) begin n_fail++; $display("FAIL dir%0d_hilo got %h want %h", k, {bus.hi, bus.lo}, exp); end
        end
    endtask

    task automatic test_random();
        int starts, cyc; logic [W-1:0] m1, m2, a, b; logic e; bit fin, sgn;
        logic [2*W-1:0] exp;
        for (int k = 0; k < 24; k++) begin
            a   = W'($urandom);
            b   = W'($urandom);
            if (k % 8 == 3) a = 16'h8000;
            if (k % 8 == 5) b = 16'hFFFF;
            sgn = 1'($urandom);
            lat = $urandom_range(0, 6);
            run_op(a, b, sgn, starts, m1, m2, e, cyc, fin);
            exp = ref_prod(a, b, sgn);
            n_checks++; if (!fin || starts !== 1) begin n_fail++; $display("FAIL rnd%0d_flow fin %0b starts %0d want 1/1", k, fin, starts); end
            n_checks++; if (m1 !== ref_mag(a, sgn) || m2 !== ref_mag(b, sgn)) begin n_fail++; $display("FAIL rnd%0d_mags got %h/%h want %h/%h", k, m1, m2, ref_mag(a, sgn), ref_mag(b, sgn)); end
            n_checks++; if ({bus.hi, bus.lo} !== exp) begin n_fail++; $display("FAIL rnd%0d_hilo a=%h b=%h s=%0b got %h want %h", k, a, b, sgn, {bus.hi, bus.lo}, exp); end
        end
    endtask

    task automatic test_stale_done();
        int starts, cyc; logic [W-1:0] m1, m2; logic e; bit fin;
        lat = 2; stale_hold = 0;
        run_op(16'd100, 16'd100, 1'b0, starts, m1, m2, e, cyc, fin);
        n_checks++; if (bus.mul_done !== 1'b1) begin n_fail++; $display("FAIL stale_setup done got %0b want 1", bus.mul_done); end
        stale_hold = GUARD;
        run_op(16'd7, 16'hFFF7, 1'b1, starts, m1, m2, e, cyc, fin);
        n_checks++; if (!fin) begin n_fail++; $display("FAIL stale_done busy never fell"); end
        n_checks++; if ({bus.hi, bus.lo} !== ref_prod(16'd7, 16'hFFF7, 1'b1)) begin n_fail++; $display("FAIL stale_hilo got %h want %h", {bus.hi, bus.lo}, ref_prod(16'd7, 16'hFFF7, 1'b1)); end
        stale_hold = 0;
    endtask

    task automatic test_timeout();
        int starts, cyc; logic [W-1:0] m1, m2; logic e; bit fin;
        logic [W-1:0] hi0, lo0;
        lat = 1;
        run_op(16'd3, 16'd5, 1'b0, starts, m1, m2, e, cyc, fin);
        hi0 = bus.hi; lo0 = bus.lo;
        mul_en = 1'b0;
        run_op(16'h1111, 16'd2, 1'b0, starts, m1, m2, e, cyc, fin);
        n_checks++; if (!fin) begin n_fail++; $display("FAIL tmo_exit busy never fell"); end
        n_checks++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL tmo_err got %0b want 1", bus.err); end
        n_checks++; if (bus.hi !== hi0 || bus.lo !== lo0) begin n_fail++; $display("FAIL tmo_hilo got %h/%h want %h/%h", bus.hi, bus.lo, hi0, lo0); end
        n_checks++; if (cyc < TIMEOUT + 1 || cyc > TIMEOUT + 2) begin n_fail++; $display("FAIL tmo_len busy cycles %0d want %0d..%0d", cyc, TIMEOUT + 1, TIMEOUT + 2); end
        repeat (2) @(negedge clk);
        n_checks++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky got %0b want 1", bus.err); end
        mul_en = 1'b1;
        run_op(16'hFFFD, 16'hFFFB, 1'b1, starts, m1, m2, e, cyc, fin);
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL tmo_clear err got %0b want 0", e); end
        n_checks++; if ({bus.hi, bus.lo} !== 32'h0000000F) begin n_fail++; $display("FAIL tmo_next_hilo got %h want 0000000f", {bus.hi, bus.lo}); end
    endtask

    task automatic test_reset_mid();
        lat = 20;
        @(negedge clk);
        bus.op_a = 16'd9; bus.op_b = 16'd9; bus.op_signed = 1'b0; bus.op_valid = 1'b1;
        @(negedge clk);
        bus.op_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre busy got %0b want 1", bus.busy); end
        rst = 1'b1;
        #1;
        n_checks++; if (bus.busy !== 1'b0 || bus.mul_start !== 1'b0) begin n_fail++; $display("FAIL rstmid_ctl busy %0b start %0b want 0/0", bus.busy, bus.mul_start); end
        n_checks++; if (bus.hi !== '0 || bus.lo !== '0) begin n_fail++; $display("FAIL rstmid_hilo got %h/%h want 0/0", bus.hi, bus.lo); end
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0 || bus.hi !== '0 || bus.lo !== '0) begin n_fail++; $display("FAIL rstmid_idle busy %0b hi %h lo %h want 0", bus.busy, bus.hi, bus.lo); end
    endtask

    task automatic test_mthi_mtlo();
        bit fin;
        lat = 6;
        @(negedge clk);
        bus.op_a = 16'd2; bus.op_b = 16'd2; bus.op_signed = 1'b1; bus.op_valid = 1'b1;
        @(negedge clk);
        bus.op_valid = 1'b0;
        @(negedge clk);
        bus.wr_hi = 1'b1; bus.wr_data = 16'h1234;
        @(negedge clk);
        bus.wr_hi = 1'b0;
        n_checks++; if (bus.hi !== 16'h1234) begin n_fail++; $display("FAIL mthi_wait got %h want 1234", bus.hi); end
        fin = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!bus.busy) begin fin = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++; if (!fin) begin n_fail++; $display("FAIL mthi_done busy never fell"); end
        n_checks++; if (bus.hi !== 16'h0000 || bus.lo !== 16'h0004) begin n_fail++; $display("FAIL mthi_over got %h/%h want 0000/0004", bus.hi, bus.lo); end
        bus.wr_lo = 1'b1; bus.wr_data = 16'hBEEF;
        @(negedge clk);
        bus.wr_lo = 1'b0;
        n_checks++; if (bus.lo !== 16'hBEEF || bus.hi !== 16'h0000) begin n_fail++; $display("FAIL mtlo_idle got %h/%h want 0000/beef", bus.hi, bus.lo); end
    endtask

    task automatic test_write_collision();
        int starts, cyc; logic [W-1:0] m1, m2; logic e; bit fin;
        lat = 2;
        bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wr_data = 16'hAAAA;
        run_op(16'hFFFD, 16'd5, 1'b1, starts, m1, m2, e, cyc, fin);
        n_checks++; if (bus.hi !== 16'hFFFF || bus.lo !== 16'hFFF1) begin n_fail++; $display("FAIL collide_hilo got %h/%h want ffff/fff1", bus.hi, bus.lo); end
        bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
        run_op(16'd3, 16'd5, 1'b0, starts, m1, m2, e, cyc, fin);
        n_checks++; if (bus.hi !== 16'h0000 || bus.lo !== 16'h000F) begin n_fail++; $display("FAIL after_collide got %h/%h want 0000/000f", bus.hi, bus.lo); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_stale_done();
        test_timeout();
        test_reset_mid();
        test_mthi_mtlo();
        test_write_collision();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
